// File: rtl/axil_to_apb.sv
// AXI-Lite to APB4 bridge: per-slot PSEL decode, one transaction in flight, alternating read/write priority.
// Latency: accept at T -> SETUP T+1, ACCESS T+2, B/R valid T+3 (+1 per APB wait state); decode miss valid at T+1.
// Backpressure: AW+W / AR ready only in IDLE; B/R held stable until ready. `AXIL2APB_TIMEOUT_EN adds an ACCESS abort timer.

package axil_to_apb_pkg;
    typedef struct packed { logic [31:0] addr; logic [2:0] prot; } axil_aw_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } axil_w_t;
    typedef struct packed { logic [1:0] resp; } axil_b_t;
    typedef struct packed { logic [31:0] addr; logic [2:0] prot; } axil_ar_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } axil_r_t;

    typedef struct packed {
        axil_aw_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ar_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axil_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        axil_b_t  b;
        logic     b_valid;
        logic     ar_ready;
        axil_r_t  r;
        logic     r_valid;
    } axil_resp_t;
endpackage

module axil_to_apb #(
    parameter int unsigned NUM_SLV        = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter int unsigned SLV_SIZE_LOG2  = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter type         req_t          = axil_to_apb_pkg::axil_req_t,
    parameter type         resp_t         = axil_to_apb_pkg::axil_resp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  req_t                  req_i,
    output resp_t                 resp_o,
    output logic [31:0]           paddr_o,
    output logic [2:0]            pprot_o,
    output logic [NUM_SLV-1:0]    psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    output logic [3:0]            pstrb_o,
    input  logic [NUM_SLV*32-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]    pready_i,
    input  logic [NUM_SLV-1:0]    pslverr_i
);

    localparam int unsigned SLOT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    if (NUM_SLV < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("axil_to_apb: NUM_SLV and TIMEOUT_CYCLES must both be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                prio_rd_q;
    logic                write_q;
    logic [31:0]         addr_q;
    logic [2:0]          prot_q;
    logic [31:0]         wdata_q;
    logic [3:0]          strb_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [1:0]          resp_q;
    logic [31:0]         rdata_q;

    logic                wr_elig, rd_elig, grant_rd, grant_wr, accept;
    logic [31:0]         acc_addr;
    logic [32:0]         acc_off, acc_slot;
    logic                acc_hit;
    logic                sel_ready, sel_err, timeout_hit;
    logic [31:0]         sel_rdata;

`ifdef AXIL2APB_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    logic [CNT_W-1:0] cnt_q;

    // Count stalled ACCESS cycles; restarts whenever SETUP hands over to ACCESS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !sel_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    // Arbitration, address decode and selected-slot APB return path.
    always_comb begin
        wr_elig   = req_i.aw_valid && req_i.w_valid;
        rd_elig   = req_i.ar_valid;
        grant_rd  = (state_q == IDLE) && !rst_i && rd_elig && (prio_rd_q || !wr_elig);
        grant_wr  = (state_q == IDLE) && !rst_i && wr_elig && !grant_rd;
        accept    = grant_rd || grant_wr;
        acc_addr  = grant_wr ? req_i.aw.addr : req_i.ar.addr;
        // 33-bit offset so addresses below the window cannot wrap into a valid slot.
        acc_off   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
        acc_slot  = acc_off >> SLV_SIZE_LOG2;
        acc_hit   = (acc_addr >= BASE_ADDR) && (acc_slot < 33'(NUM_SLV));
        sel_ready = pready_i[slot_q];
        sel_err   = pslverr_i[slot_q];
        sel_rdata = prdata_i[32*int'(slot_q) +: 32];
`ifdef AXIL2APB_TIMEOUT_EN
        timeout_hit = !sel_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        timeout_hit = 1'b0;
`endif
    end

    // Next-state and output decode; readies are combinational grants in IDLE.
    always_comb begin
        state_d         = state_q;
        resp_o          = '0;
        psel_o          = '0;
        penable_o       = 1'b0;
        resp_o.aw_ready = grant_wr;
        resp_o.w_ready  = grant_wr;
        resp_o.ar_ready = grant_rd;
        resp_o.b.resp   = resp_q;
        resp_o.r.resp   = resp_q;
        resp_o.r.data   = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = acc_hit ? SETUP : RESP;
            end
            SETUP: begin
                psel_o[slot_q] = 1'b1;
                state_d        = ACCESS;
            end
            ACCESS: begin
                psel_o[slot_q] = 1'b1;
                penable_o      = 1'b1;
                if (sel_ready || timeout_hit) state_d = RESP;
            end
            RESP: begin
                resp_o.b_valid = write_q;
                resp_o.r_valid = !write_q;
                if ((write_q && req_i.b_ready) || (!write_q && req_i.r_ready)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign paddr_o  = addr_q;
    assign pprot_o  = prot_q;
    assign pwrite_o = write_q;
    assign pwdata_o = wdata_q;
    assign pstrb_o  = strb_q;

    // State, request capture on accept, and response capture on APB completion or decode miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b1;
            write_q   <= 1'b0;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            slot_q    <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                prio_rd_q <= grant_wr;
                write_q   <= grant_wr;
                addr_q    <= acc_addr;
                prot_q    <= grant_wr ? req_i.aw.prot : req_i.ar.prot;
                wdata_q   <= grant_wr ? req_i.w.data : 32'h0;
                strb_q    <= grant_wr ? req_i.w.strb : 4'h0;
                slot_q    <= acc_slot[SLOT_W-1:0];
                if (!acc_hit) begin
                    resp_q  <= 2'b11;
                    rdata_q <= '0;
                end
            end
            if (state_q == ACCESS && sel_ready) begin
                resp_q  <= sel_err ? 2'b10 : 2'b00;
                rdata_q <= write_q ? 32'h0 : sel_rdata;
            end else if (state_q == ACCESS && timeout_hit) begin
                resp_q  <= 2'b10;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axil_to_apb.sv
// Directed bench for axil_to_apb: reset, APB write/read with wait states, decode miss, priority, slave error, reset abort.
// Latency: checks exact cycle positions of SETUP/ACCESS/response relative to the accept cycle.
// Backpressure: holds b_ready/r_ready low to observe stable responses; optional timeout test under the build macro.

module tb_axil_to_apb;
    import axil_to_apb_pkg::*;

`ifdef AXIL2APB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic         clk = 1'b0;
    logic         rst;
    axil_req_t    req;
    axil_resp_t   resp;
    logic [31:0]  paddr;
    logic [2:0]   pprot;
    logic [3:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    int checks = 0;
    int errors = 0;
    logic [31:0] miss_addr [2];

    always #5 clk = ~clk;

    axil_to_apb #(
        .NUM_SLV        (4),
        .BASE_ADDR      (32'h0001_0000),
        .SLV_SIZE_LOG2  (12),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .resp_o    (resp),
        .paddr_o   (paddr),
        .pprot_o   (pprot),
        .psel_o    (psel),
        .penable_o (penable),
        .pwrite_o  (pwrite),
        .pwdata_o  (pwdata),
        .pstrb_o   (pstrb),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        req.ar_valid = 1'b1;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        pready = '0; pslverr = '0; prdata = '0;
        tick; tick; #1;
        checks++; if (resp !== '0) begin errors++; $display("FAIL reset_resp: got %h expected 0", resp); end
        checks++; if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin errors++; $display("FAIL reset_apb: got psel=%b en=%b wr=%b addr=%h wdata=%h strb=%h prot=%h expected all 0", psel, penable, pwrite, paddr, pwdata, pstrb, pprot); end
        req = '0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write;
        pready = 4'b0010; pslverr = '0;
        req.aw.addr = 32'h0001_1004; req.aw.prot = 3'b010;
        req.w.data = 32'hDEAD_BEEF; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; #1;
        checks++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b110) begin errors++; $display("FAIL wr_accept: got %b expected 110", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
        tick; req.aw_valid = 1'b0; req.w_valid = 1'b0; #1;
        checks++; if ({psel, penable} !== 5'b0010_0) begin errors++; $display("FAIL wr_setup_sel: got psel=%b en=%b expected 0010/0", psel, penable); end
        checks++; if ({paddr, pwrite, pwdata, pstrb, pprot} !== {32'h0001_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin errors++; $display("FAIL wr_setup_bus: got addr=%h wr=%b data=%h strb=%h prot=%b", paddr, pwrite, pwdata, pstrb, pprot); end
        tick; #1;
        checks++; if ({psel, penable, resp.b_valid} !== {4'b0010, 1'b1, 1'b0}) begin errors++; $display("FAIL wr_access: got psel=%b en=%b bvld=%b expected 0010/1/0", psel, penable, resp.b_valid); end
        tick; #1;
        checks++; if ({resp.b_valid, resp.b.resp, psel, penable} !== {1'b1, 2'b00, 4'b0000, 1'b0}) begin errors++; $display("FAIL wr_bresp: got bvld=%b resp=%b psel=%b en=%b expected 1/00/0000/0", resp.b_valid, resp.b.resp, psel, penable); end
        req.b_ready = 1'b1; tick; req.b_ready = 1'b0; #1;
        checks++; if (resp.b_valid !== 1'b0) begin errors++; $display("FAIL wr_b_done: got %b expected 0", resp.b_valid); end
    endtask

    task automatic test_read_wait;
        prdata = '0;
        prdata[127:96] = 32'h1234_5678;
        prdata[63:32]  = 32'hFFFF_FFFF;
        pready = 4'b0111; pslverr = 4'b0111;
        req.ar.addr = 32'h0001_3010; req.ar.prot = 3'b000; req.ar_valid = 1'b1; #1;
        checks++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b001) begin errors++; $display("FAIL rd_accept: got %b expected 001", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
        tick; req.ar_valid = 1'b0; #1;
        checks++; if ({psel, penable, pwrite, pwdata, pstrb, paddr} !== {4'b1000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0001_3010}) begin errors++; $display("FAIL rd_setup: got psel=%b en=%b wr=%b wdata=%h strb=%h addr=%h", psel, penable, pwrite, pwdata, pstrb, paddr); end
        tick; #1;
        checks++; if ({psel, penable, resp.r_valid} !== {4'b1000, 1'b1, 1'b0}) begin errors++; $display("FAIL rd_wait1: got psel=%b en=%b rvld=%b expected 1000/1/0", psel, penable, resp.r_valid); end
        tick; #1;
        checks++; if ({psel, penable, resp.r_valid} !== {4'b1000, 1'b1, 1'b0}) begin errors++; $display("FAIL rd_wait2: got psel=%b en=%b rvld=%b expected 1000/1/0", psel, penable, resp.r_valid); end
        tick; pready[3] = 1'b1; #1;
        checks++; if ({psel, penable, resp.r_valid} !== {4'b1000, 1'b1, 1'b0}) begin errors++; $display("FAIL rd_ready_cycle: got psel=%b en=%b rvld=%b expected 1000/1/0", psel, penable, resp.r_valid); end
        tick; #1;
        checks++; if ({resp.r_valid, resp.r.resp, resp.r.data, psel, penable} !== {1'b1, 2'b00, 32'h1234_5678, 4'b0000, 1'b0}) begin errors++; $display("FAIL rd_rdata: got rvld=%b resp=%b data=%h psel=%b en=%b expected 1/00/12345678/0000/0", resp.r_valid, resp.r.resp, resp.r.data, psel, penable); end
        req.r_ready = 1'b1; tick; req.r_ready = 1'b0; #1;
        checks++; if (resp.r_valid !== 1'b0) begin errors++; $display("FAIL rd_done: got %b expected 0", resp.r_valid); end
        pready = '0; pslverr = '0;
    endtask

    task automatic test_decode_miss;
        pready = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            req.ar.addr = miss_addr[i]; req.ar_valid = 1'b1; #1;
            checks++; if (resp.ar_ready !== 1'b1) begin errors++; $display("FAIL miss_accept[%0d]: got %b expected 1", i, resp.ar_ready); end
            tick; req.ar_valid = 1'b0; #1;
            checks++; if ({resp.r_valid, resp.r.resp, resp.r.data, psel, penable} !== {1'b1, 2'b11, 32'h0, 4'b0000, 1'b0}) begin errors++; $display("FAIL miss_resp[%0d]: got rvld=%b resp=%b data=%h psel=%b en=%b expected 1/11/0/0000/0", i, resp.r_valid, resp.r.resp, resp.r.data, psel, penable); end
            req.r_ready = 1'b1; tick; req.r_ready = 1'b0; #1;
            checks++; if ({resp.r_valid, psel} !== 5'b0) begin errors++; $display("FAIL miss_done[%0d]: got rvld=%b psel=%b expected 0/0000", i, resp.r_valid, psel); end
        end
        pready = '0;
    endtask

    task automatic test_priority;
        rst = 1'b1; tick; rst = 1'b0;
        pready = 4'b1111; pslverr = '0;
        prdata = '0; prdata[31:0] = 32'hCAFE_0000;
        req.ar.addr = 32'h0001_0000; req.ar_valid = 1'b1;
        req.aw.addr = 32'h0001_2000; req.w.data = 32'h0000_00AA; req.w.strb = 4'h1;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; #1;
        checks++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b001) begin errors++; $display("FAIL prio_first_read: got %b expected 001", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
        tick; req.ar_valid = 1'b0; #1;
        checks++; if ({resp.aw_ready, resp.w_ready} !== 2'b00) begin errors++; $display("FAIL prio_busy: got %b expected 00", {resp.aw_ready, resp.w_ready}); end
        tick; tick; #1;
        checks++; if ({resp.r_valid, resp.r.data} !== {1'b1, 32'hCAFE_0000}) begin errors++; $display("FAIL prio_read_data: got rvld=%b data=%h expected 1/cafe0000", resp.r_valid, resp.r.data); end
        req.r_ready = 1'b1; tick; req.r_ready = 1'b0; #1;
        checks++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b110) begin errors++; $display("FAIL prio_write_next: got %b expected 110", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
        tick; req.aw_valid = 1'b0; req.w_valid = 1'b0;
        tick; tick; #1;
        checks++; if ({resp.b_valid, resp.b.resp} !== 3'b100) begin errors++; $display("FAIL prio_write_done: got bvld=%b resp=%b expected 1/00", resp.b_valid, resp.b.resp); end
        req.b_ready = 1'b1; tick; req.b_ready = 1'b0;
        req.ar_valid = 1'b1; req.aw_valid = 1'b1; req.w_valid = 1'b1; #1;
        checks++; if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b001) begin errors++; $display("FAIL prio_third_read: got %b expected 001", {resp.aw_ready, resp.w_ready, resp.ar_ready}); end
        tick; req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
        tick; tick; #1;
        checks++; if (resp.r_valid !== 1'b1) begin errors++; $display("FAIL prio_third_done: got rvld=%b expected 1", resp.r_valid); end
        req.r_ready = 1'b1; tick; req.r_ready = 1'b0;
        pready = '0;
    endtask

    task automatic test_slverr;
        pready = 4'b0100; pslverr = 4'b0100;
        req.aw.addr = 32'h0001_2008; req.aw.prot = 3'b000;
        req.w.data = 32'hA5A5_A5A5; req.w.strb = 4'hC;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; #1;
        checks++; if ({resp.aw_ready, resp.w_ready} !== 2'b11) begin errors++; $display("FAIL err_accept: got %b expected 11", {resp.aw_ready, resp.w_ready}); end
        tick; req.aw_valid = 1'b0; req.w_valid = 1'b0;
        tick; tick; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({resp.b_valid, resp.b.resp, resp.r_valid} !== {1'b1, 2'b10, 1'b0}) begin errors++; $display("FAIL err_hold[%0d]: got bvld=%b resp=%b rvld=%b expected 1/10/0", i, resp.b_valid, resp.b.resp, resp.r_valid); end
            tick; #1;
        end
        req.b_ready = 1'b1; tick; req.b_ready = 1'b0; #1;
        checks++; if (resp.b_valid !== 1'b0) begin errors++; $display("FAIL err_done: got %b expected 0", resp.b_valid); end
        pready = '0; pslverr = '0;
    endtask

    task automatic test_reset_mid;
        pready = '0;
        req.ar.addr = 32'h0001_0040; req.ar.prot = 3'b001; req.ar_valid = 1'b1; #1;
        tick; req.ar_valid = 1'b0;
        tick; #1;
        checks++; if ({psel, penable} !== 5'b0001_1) begin errors++; $display("FAIL rst_mid_access: got psel=%b en=%b expected 0001/1", psel, penable); end
        rst = 1'b1; tick; #1;
        checks++; if (resp !== '0) begin errors++; $display("FAIL rst_mid_resp: got %h expected 0", resp); end
        checks++; if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot} !== '0) begin errors++; $display("FAIL rst_mid_apb: got psel=%b en=%b addr=%h prot=%b expected all 0", psel, penable, paddr, pprot); end
        rst = 1'b0; pready = 4'hF; tick; tick; #1;
        checks++; if ({resp.r_valid, resp.b_valid, psel} !== 6'b0) begin errors++; $display("FAIL rst_mid_no_resp: got rvld=%b bvld=%b psel=%b expected 0/0/0000", resp.r_valid, resp.b_valid, psel); end
        pready = '0;
    endtask

`ifdef AXIL2APB_TIMEOUT_EN
    task automatic test_timeout;
        pready = '0;
        req.ar.addr = 32'h0001_1000; req.ar_valid = 1'b1; #1;
        tick; req.ar_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick; #1;
            checks++; if ({psel, penable, resp.r_valid} !== {4'b0010, 1'b1, 1'b0}) begin errors++; $display("FAIL to_access[%0d]: got psel=%b en=%b rvld=%b expected 0010/1/0", i, psel, penable, resp.r_valid); end
        end
        tick; #1;
        checks++; if ({resp.r_valid, resp.r.resp, resp.r.data, psel, penable} !== {1'b1, 2'b10, 32'h0, 4'b0000, 1'b0}) begin errors++; $display("FAIL to_slverr: got rvld=%b resp=%b data=%h psel=%b en=%b expected 1/10/0/0000/0", resp.r_valid, resp.r.resp, resp.r.data, psel, penable); end
        pready = 4'hF; req.r_ready = 1'b1; tick; req.r_ready = 1'b0; #1;
        checks++; if ({resp.r_valid, psel} !== 5'b0) begin errors++; $display("FAIL to_done: got rvld=%b psel=%b expected 0/0000", resp.r_valid, psel); end
        pready = '0;
    endtask
`endif

    initial begin
        miss_addr[0] = 32'h0000_0100;
        miss_addr[1] = 32'h0001_4000;
        test_reset;
        test_write;
        test_read_wait;
        test_decode_miss;
        test_priority;
        test_slverr;
        test_reset_mid;
`ifdef AXIL2APB_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
